// File: rtl/sys_a.sv
// ---------------------------------------------------------------------------
// sys_a -- 3x3 weight-stationary systolic matrix-multiply core
//
// Weights sit still (read combinationally from w). Activation vectors enter
// on the left at one per enabled cycle and shift one column to the right per
// enabled cycle. Each column sums its three products into a registered 16-bit
// result, so column c's result for a given vector appears c cycles after
// column 0's result.
//
// Ports
//   clk   in   1    rising-edge clock
//   rst   in   1    synchronous, active-high reset (wins over en)
//   en    in   1    advance enable; 0 freezes activations and outputs
//   w     in   97   weights, W[r][c] = w[(3*r+c)*8 +: 8]; bits 96:72 unused
//   in    in   24   activation vector, x[r] = in[8*r +: 8]
//   out1  out  16   column 0 result (registered)
//   out2  out  16   column 1 result (registered)
//   out3  out  16   column 2 result (registered)
// ---------------------------------------------------------------------------

// Processing element: one activation register plus one unsigned multiplier.
// The product is formed from the activation arriving at this PE this cycle,
// so a column's result is registered in the same edge the activation lands.
module sys_a_pe #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   w_in,
    output logic [DW-1:0]   a_out,
    output logic [2*DW-1:0] prod
);
    logic [DW-1:0] a_q;
    logic [DW-1:0] a_d;

    always_comb begin
        a_d = a_q;
        if (en) a_d = a_in;
    end

    always_ff @(posedge clk) begin
        if (rst) a_q <= '0;
        else     a_q <= a_d;
    end

    assign a_out = a_q;
    assign prod  = w_in * a_in;
endmodule

module sys_a #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [96:0]   w,
    input  logic [23:0]   in,
    output logic [OW-1:0] out1,
    output logic [OW-1:0] out2,
    output logic [OW-1:0] out3
);
    // a_src[r][c]: activation arriving at PE(r,c) this cycle.
    // a_reg[r][c]: activation held in PE(r,c) after the last enabled edge.
    logic [N-1:0][N-1:0][DW-1:0]   a_src;
    logic [N-1:0][N-1:0][DW-1:0]   a_reg;
    logic [N-1:0][N-1:0][DW-1:0]   w_el;
    logic [N-1:0][N-1:0][2*DW-1:0] prod;

    logic [N-1:0][OW-1:0] out_q;
    logic [N-1:0][OW-1:0] out_d;

    // Upper weight bits are spare in the port map.
    logic unused_w;
    assign unused_w = ^w[96:N*N*DW];

    genvar r, c;
    generate
        for (r = 0; r < N; r++) begin : g_row
            for (c = 0; c < N; c++) begin : g_col
                assign w_el[r][c] = w[(N*r+c)*DW +: DW];

                if (c == 0) begin : g_edge
                    assign a_src[r][c] = in[DW*r +: DW];
                end else begin : g_inner
                    assign a_src[r][c] = a_reg[r][c-1];
                end

                sys_a_pe #(.DW(DW)) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .en    (en),
                    .a_in  (a_src[r][c]),
                    .w_in  (w_el[r][c]),
                    .a_out (a_reg[r][c]),
                    .prod  (prod[r][c])
                );
            end
        end
    endgenerate

    // Column sums wrap modulo 2^OW; no saturation.
    always_comb begin
        out_d = out_q;
        if (en) begin
            for (int cc = 0; cc < N; cc++) begin
                out_d[cc] = '0;
                for (int rr = 0; rr < N; rr++) begin
                    out_d[cc] = out_d[cc] + OW'(prod[rr][cc]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out1 = out_q[0];
    assign out2 = out_q[1];
    assign out3 = out_q[2];
endmodule

// File: tb/tb_sys_a.sv
module tb_sys_a;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [96:0] w   = '0;
    logic [23:0] in  = '0;
    logic [15:0] out1, out2, out3;

    int checks = 0;
    int passes = 0;

    // Reference model: every vector accepted since the last reset, newest last.
    // Column c's result after an enabled edge is the dot product of the vector
    // accepted c edges earlier with weight column c (weights as of that edge).
    logic [23:0] vq[$];
    logic [15:0] exp_out [3];

    sys_a dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .w    (w),
        .in   (in),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3)
    );

    always #5 clk = ~clk;

    function automatic int wt(input logic [96:0] wv, input int r, input int c);
        return int'(wv[(3*r+c)*8 +: 8]);
    endfunction

    function automatic int xv(input logic [23:0] v, input int r);
        return int'(v[8*r +: 8]);
    endfunction

    function automatic logic [15:0] dut_col(input int c);
        return (c == 0) ? out1 : (c == 1) ? out2 : out3;
    endfunction

    // Drive one cycle, advance the model, sample outputs 1ns after the edge.
    task automatic cycle(input logic r_v, input logic e_v,
                         input logic [96:0] w_v, input logic [23:0] i_v);
        rst = r_v; en = e_v; w = w_v; in = i_v;
        if (r_v) begin
            vq.delete();
            for (int c = 0; c < 3; c++) exp_out[c] = '0;
        end else if (e_v) begin
            vq.push_back(i_v);
            if (vq.size() > 3) void'(vq.pop_front());
            for (int c = 0; c < 3; c++) begin
                int idx;
                int s;
                idx = vq.size() - 1 - c;
                s = 0;
                if (idx >= 0)
                    for (int r = 0; r < 3; r++) s += wt(w_v, r, c) * xv(vq[idx], r);
                exp_out[c] = s[15:0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [96:0] w_rowmajor();
        logic [96:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(k + 1);
        return v;
    endfunction

    function automatic logic [23:0] vec(input int x0, input int x1, input int x2);
        return {8'(x2), 8'(x1), 8'(x0)};
    endfunction

    task automatic test_reset();
        cycle(1'b0, 1'b1, {97{1'b1}}, 24'hA5C3FF);
        cycle(1'b1, 1'b1, {97{1'b1}}, 24'hA5C3FF);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dut_col(c) !== 16'd0)
                $display("FAIL reset out%0d got %0d want 0", c + 1, dut_col(c));
            else passes++;
        end
    endtask

    task automatic test_identity();
        logic [96:0] wi;
        logic [15:0] want [3];
        wi = '0;
        wi[0*8 +: 8] = 8'd1; wi[4*8 +: 8] = 8'd1; wi[8*8 +: 8] = 8'd1;
        cycle(1'b1, 1'b0, wi, '0);
        want = '{16'd1, 16'd2, 16'd3};
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, wi, (k == 0) ? vec(1, 2, 3) : 24'd0);
            checks++;
            if (dut_col(k) !== want[k])
                $display("FAIL identity out%0d after edge%0d got %0d want %0d",
                         k + 1, k, dut_col(k), want[k]);
            else passes++;
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, {97{1'b1}}, '0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, {97{1'b1}}, 24'hFFFFFF);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dut_col(c) !== 16'd64003)
                $display("FAIL overflow out%0d got %0d want 64003", c + 1, dut_col(c));
            else passes++;
        end
    endtask

    task automatic test_streaming();
        logic [23:0] vs [5];
        logic [15:0] want [3][3];
        vs = '{vec(1,1,1), vec(1,0,0), vec(0,0,1), 24'd0, 24'd0};
        want = '{'{16'd12, 16'd1, 16'd7}, '{16'd15, 16'd2, 16'd8}, '{16'd18, 16'd3, 16'd9}};
        cycle(1'b1, 1'b0, w_rowmajor(), '0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, w_rowmajor(), vs[k]);
            for (int c = 0; c < 3; c++) begin
                if (k - c >= 0 && k - c < 3) begin
                    checks++;
                    if (dut_col(c) !== want[c][k-c])
                        $display("FAIL stream out%0d edge%0d got %0d want %0d",
                                 c + 1, k, dut_col(c), want[c][k-c]);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [23:0] vs [6];
        vs = '{vec(1,1,1), vec(1,0,0), vec(0,0,1), vec(2,3,4), 24'd0, 24'd0};
        cycle(1'b1, 1'b0, w_rowmajor(), '0);
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b1, w_rowmajor(), vs[k]);
        // Inputs keep changing while frozen; nothing may enter.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, w_rowmajor(), 24'($urandom));
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dut_col(c) !== exp_out[c])
                    $display("FAIL hold out%0d frozen got %0d want %0d", c + 1, dut_col(c), exp_out[c]);
                else passes++;
            end
        end
        for (int k = 2; k < 6; k++) begin
            cycle(1'b0, 1'b1, w_rowmajor(), vs[k]);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dut_col(c) !== exp_out[c])
                    $display("FAIL hold out%0d resume got %0d want %0d", c + 1, dut_col(c), exp_out[c]);
                else passes++;
            end
        end
    endtask

    task automatic test_midstream_reset();
        cycle(1'b1, 1'b0, w_rowmajor(), '0);
        cycle(1'b0, 1'b1, w_rowmajor(), vec(1,1,1));
        cycle(1'b0, 1'b1, w_rowmajor(), vec(1,0,0));
        cycle(1'b1, 1'b1, w_rowmajor(), vec(5,5,5));
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dut_col(c) !== 16'd0)
                $display("FAIL midreset out%0d got %0d want 0", c + 1, dut_col(c));
            else passes++;
        end
        // Only the post-reset vector (0,0,1) may show up; older ones are gone.
        cycle(1'b0, 1'b1, w_rowmajor(), vec(0,0,1));
        cycle(1'b0, 1'b1, w_rowmajor(), 24'd0);
        cycle(1'b0, 1'b1, w_rowmajor(), 24'd0);
        checks++;
        if (out3 !== 16'd9) $display("FAIL midreset out3 got %0d want 9", out3);
        else passes++;
        checks++;
        if (out2 !== 16'd0) $display("FAIL midreset out2 drained got %0d want 0", out2);
        else passes++;
    endtask

    task automatic test_random();
        logic [96:0] wr;
        wr = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b0, wr, '0);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) wr = {$urandom, $urandom, $urandom, $urandom};
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 4) != 0, wr, 24'($urandom));
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dut_col(c) !== exp_out[c])
                    $display("FAIL random cyc%0d out%0d got %0d want %0d", k, c + 1, dut_col(c), exp_out[c]);
                else passes++;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 3; c++) exp_out[c] = '0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_overflow();
        test_streaming();
        test_enable_hold();
        test_midstream_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
